pamac_term_sched: RTL and testbench

- Sequencer for the PAMAC control path.
- Accepts one multiply job: both operands' Booth digit registers plus their essential-term counts (ETC).
- Picks the operand to decompose using the same rule as the PAMAC select logic, then issues one Booth-digit select per cycle, skipping zero digits.
- Drives BPEB_sel/mul_sel into the PAMAC control path, and term_first/term_last into the downstream partial-sum accumulator.

---
 rtl/pamac_term_sched.sv | 129 ++++++++++++
 tb/tb_pamac_term_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pamac_term_sched.sv
// PAMAC term sequencer: latches one multiply job, picks the operand to decompose and
// walks its nonzero Booth digits one select per cycle, lowest index first.
module pamac_term_sched #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 3,
  parameter int SEL_W      = 3,
  parameter int ETC_BITS   = 4   // ETC input width; the name ETC_W belongs to the weight-count port
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ETC_BITS-1:0]           ETC_A,
  input  logic [ETC_BITS-1:0]           ETC_W,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] BPR_A,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] BPR_W,
  input  logic                          MDecomp,
  input  logic                          AWDecomp,
  input  logic                          abort,
  output logic                          term_valid,
  input  logic                          term_ready,
  output logic [SEL_W-1:0]              BPEB_sel,
  output logic                          mul_sel,
  output logic [SEL_W:0]                term_shift,
  output logic                          term_first,
  output logic                          term_last,
  output logic                          done,
  output logic                          zero_job,
  output logic                          etc_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ZDONE = 2'd2;

  logic [1:0]                    state;
  logic [NUM_DIGITS-1:0]         mask, new_mask, low_bit;
  logic                          first_q, sel_dec, one_left, run, accept, mismatch;
  logic [NUM_DIGITS*DIGIT_W-1:0] bpr_sel;
  logic [ETC_BITS-1:0]           etc_sel;
  logic [SEL_W:0]                pop;
  logic [SEL_W-1:0]              idx;
  logic [DIGIT_W-1:0]            digit;

  assign sel_dec = MDecomp ? (ETC_A > ETC_W) : AWDecomp;
  assign bpr_sel = sel_dec ? BPR_W : BPR_A;
  assign etc_sel = sel_dec ? ETC_W : ETC_A;

  // 000 and 111 are both Booth zero codes and never produce a term
  always_comb begin
    new_mask = '0;
    pop      = '0;
    digit    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit       = bpr_sel[DIGIT_W*i +: DIGIT_W];
      new_mask[i] = !((digit == '0) || (digit == '1));
      pop         = pop + (SEL_W+1)'(new_mask[i]);
    end
  end
  assign mismatch = 32'(pop) != 32'(etc_sel);

  // Descending scan so the lowest set bit wins
  always_comb begin
    idx     = '0;
    low_bit = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      if (mask[i]) begin
        idx        = SEL_W'(i);
        low_bit    = '0;
        low_bit[i] = 1'b1;
      end
    end
  end

  assign one_left   = (mask != '0) && ((mask & (mask - NUM_DIGITS'(1))) == '0);
  assign run        = (state == RUN);
  assign term_valid = run;
  assign BPEB_sel   = idx;
  assign term_shift = {idx, 1'b0};
  assign term_first = run & first_q;
  assign term_last  = run & one_left;
  assign in_ready   = !rst && !abort && ((state == IDLE) || (run && term_ready && one_left));
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      first_q  <= 1'b0;
      mul_sel  <= 1'b0;
      done     <= 1'b0;
      zero_job <= 1'b0;
      etc_err  <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      mask     <= '0;
      first_q  <= 1'b0;
      done     <= 1'b0;
      zero_job <= 1'b0;
    end else begin
      done     <= 1'b0;
      zero_job <= 1'b0;
      case (state)
        RUN: if (term_ready) begin
          mask    <= mask & ~low_bit;
          first_q <= 1'b0;
          if (one_left) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        ZDONE: begin
          done     <= 1'b1;
          zero_job <= 1'b1;
          state    <= IDLE;
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
      // A same-cycle accept overrides the retiring job's state and mask
      if (accept) begin
        mul_sel <= sel_dec;
        mask    <= new_mask;
        first_q <= 1'b1;
        state   <= (new_mask != '0) ? RUN : ZDONE;
        if (mismatch) etc_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pamac_term_sched.sv
// Directed bench for pamac_term_sched: hand-computed term sequences per scenario.
module tb_pamac_term_sched;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, MDecomp, AWDecomp, abort;
  logic [3:0]  ETC_A, ETC_W;
  logic [23:0] BPR_A, BPR_W;
  logic        term_valid, term_ready, mul_sel, term_first, term_last, done, zero_job, etc_err;
  logic [2:0]  BPEB_sel;
  logic [3:0]  term_shift;
  logic [9:0]  tv;
  logic [14:0] allo;
  int total = 0;
  int bad   = 0;

  pamac_term_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ETC_A(ETC_A), .ETC_W(ETC_W), .BPR_A(BPR_A), .BPR_W(BPR_W),
    .MDecomp(MDecomp), .AWDecomp(AWDecomp), .abort(abort),
    .term_valid(term_valid), .term_ready(term_ready), .BPEB_sel(BPEB_sel),
    .mul_sel(mul_sel), .term_shift(term_shift), .term_first(term_first),
    .term_last(term_last), .done(done), .zero_job(zero_job), .etc_err(etc_err)
  );

  always #5 clk = ~clk;

  // {valid, sel, shift, first, last}
  assign tv   = {term_valid, BPEB_sel, term_shift, term_first, term_last};
  assign allo = {tv, mul_sel, done, zero_job, etc_err, in_ready};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; MDecomp = 0; AWDecomp = 0; abort = 0; term_ready = 0;
    ETC_A = 0; ETC_W = 0; BPR_A = 0; BPR_W = 0;
    #2;
    total++; if (allo !== 15'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", allo); end
    #1 rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_weight();
    logic [23:0] bw;
    bw = '0; bw[0+:3] = 3'b001; bw[9+:3] = 3'b100; bw[18+:3] = 3'b011;
    BPR_W = bw; BPR_A = {8{3'b001}}; ETC_W = 4'd3; ETC_A = 4'd5;
    MDecomp = 1; in_valid = 1; term_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wt_in_ready got=%b exp=1", in_ready); end
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL wt_term0 got=%h exp=%h", tv, {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}); end
    total++; if (mul_sel !== 1'b1) begin bad++; $display("FAIL wt_mul_sel got=%b exp=1", mul_sel); end
    step();
    total++; if (tv !== {1'b1, 3'd3, 4'd6, 1'b0, 1'b0}) begin bad++; $display("FAIL wt_term1 got=%h exp=%h", tv, {1'b1, 3'd3, 4'd6, 1'b0, 1'b0}); end
    step();
    total++; if (tv !== {1'b1, 3'd6, 4'd12, 1'b0, 1'b1}) begin bad++; $display("FAIL wt_term2 got=%h exp=%h", tv, {1'b1, 3'd6, 4'd12, 1'b0, 1'b1}); end
    step();
    total++; if ({term_valid, done, zero_job, etc_err} !== 4'b0100) begin bad++; $display("FAIL wt_done got=%b exp=0100", {term_valid, done, zero_job, etc_err}); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wt_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_awdecomp();
    logic [23:0] ba;
    ba = '0; ba[21+:3] = 3'b101;
    BPR_A = ba; BPR_W = {8{3'b010}}; ETC_A = 4'd1; ETC_W = 4'd0;
    MDecomp = 0; AWDecomp = 0; in_valid = 1; term_ready = 1;
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd7, 4'd14, 1'b1, 1'b1}) begin bad++; $display("FAIL aw_term got=%h exp=%h", tv, {1'b1, 3'd7, 4'd14, 1'b1, 1'b1}); end
    total++; if (mul_sel !== 1'b0) begin bad++; $display("FAIL aw_mul_sel got=%b exp=0", mul_sel); end
    step();
    total++; if ({term_valid, done, zero_job, etc_err} !== 4'b0100) begin bad++; $display("FAIL aw_done got=%b exp=0100", {term_valid, done, zero_job, etc_err}); end
  endtask

  task automatic test_zero_job();
    logic [23:0] ba;
    ba = '0;
    for (int i = 0; i < 8; i += 2) ba[3*i +: 3] = 3'b111;
    BPR_A = ba; BPR_W = {8{3'b011}}; ETC_A = 4'd0; ETC_W = 4'd2;
    MDecomp = 1; in_valid = 1; term_ready = 1;
    step(); in_valid = 0;
    #1;
    total++; if ({term_valid, done, in_ready} !== 3'b000) begin bad++; $display("FAIL zero_c1 got=%b exp=000", {term_valid, done, in_ready}); end
    step();
    total++; if ({term_valid, done, zero_job, etc_err, in_ready} !== 5'b01101) begin bad++; $display("FAIL zero_done got=%b exp=01101", {term_valid, done, zero_job, etc_err, in_ready}); end
    total++; if (mul_sel !== 1'b0) begin bad++; $display("FAIL zero_mul_sel got=%b exp=0", mul_sel); end
    step();
    total++; if ({done, zero_job} !== 2'b00) begin bad++; $display("FAIL zero_pulse got=%b exp=00", {done, zero_job}); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] bw;
    bw = '0; bw[3+:3] = 3'b001; bw[6+:3] = 3'b110; bw[15+:3] = 3'b010;
    BPR_W = bw; BPR_A = {8{3'b001}}; ETC_W = 4'd3; ETC_A = 4'd9;
    MDecomp = 1; in_valid = 1; term_ready = 1;
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd1, 4'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL bp_term0 got=%h exp=%h", tv, {1'b1, 3'd1, 4'd2, 1'b1, 1'b0}); end
    step(); term_ready = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (tv !== {1'b1, 3'd2, 4'd4, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", c, tv, {1'b1, 3'd2, 4'd4, 1'b0, 1'b0}); end
    end
    term_ready = 1;
    step();
    total++; if (tv !== {1'b1, 3'd5, 4'd10, 1'b0, 1'b1}) begin bad++; $display("FAIL bp_last got=%h exp=%h", tv, {1'b1, 3'd5, 4'd10, 1'b0, 1'b1}); end
    bw = '0; bw[0+:3] = 3'b110; bw[12+:3] = 3'b010;
    BPR_W = bw; ETC_W = 4'd2; MDecomp = 0; AWDecomp = 1; in_valid = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_term0 got=%h exp=%h", tv, {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}); end
    total++; if ({done, mul_sel} !== 2'b11) begin bad++; $display("FAIL b2b_done_a got=%b exp=11", {done, mul_sel}); end
    step();
    total++; if (tv !== {1'b1, 3'd4, 4'd8, 1'b0, 1'b1}) begin bad++; $display("FAIL b2b_term1 got=%h exp=%h", tv, {1'b1, 3'd4, 4'd8, 1'b0, 1'b1}); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_no_done got=%b exp=0", done); end
    step();
    total++; if ({term_valid, done, etc_err} !== 3'b010) begin bad++; $display("FAIL b2b_done_b got=%b exp=010", {term_valid, done, etc_err}); end
  endtask

  task automatic test_mismatch_abort();
    logic [23:0] bw;
    bw = '0; bw[6+:3] = 3'b001; bw[12+:3] = 3'b101; bw[21+:3] = 3'b011;
    BPR_W = bw; BPR_A = '0; ETC_W = 4'd2; ETC_A = 4'd0;
    MDecomp = 0; AWDecomp = 1; in_valid = 1; term_ready = 1;
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd2, 4'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL mm_term0 got=%h exp=%h", tv, {1'b1, 3'd2, 4'd4, 1'b1, 1'b0}); end
    total++; if (etc_err !== 1'b1) begin bad++; $display("FAIL mm_etc_err got=%b exp=1", etc_err); end
    step();
    total++; if (tv !== {1'b1, 3'd4, 4'd8, 1'b0, 1'b0}) begin bad++; $display("FAIL mm_term1 got=%h exp=%h", tv, {1'b1, 3'd4, 4'd8, 1'b0, 1'b0}); end
    step();
    total++; if (tv !== {1'b1, 3'd7, 4'd14, 1'b0, 1'b1}) begin bad++; $display("FAIL mm_term2 got=%h exp=%h", tv, {1'b1, 3'd7, 4'd14, 1'b0, 1'b1}); end
    step();
    total++; if ({term_valid, done, etc_err} !== 3'b011) begin bad++; $display("FAIL mm_done got=%b exp=011", {term_valid, done, etc_err}); end
    ETC_W = 4'd3; in_valid = 1;
    step(); in_valid = 0;
    total++; if (tv !== {1'b1, 3'd2, 4'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL ab_term0 got=%h exp=%h", tv, {1'b1, 3'd2, 4'd4, 1'b1, 1'b0}); end
    step();
    abort = 1; in_valid = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ab_in_ready got=%b exp=0", in_ready); end
    step();
    abort = 0; in_valid = 0;
    #1;
    total++; if ({term_valid, done, in_ready} !== 3'b001) begin bad++; $display("FAIL ab_idle got=%b exp=001", {term_valid, done, in_ready}); end
    step();
    total++; if ({term_valid, done} !== 2'b00) begin bad++; $display("FAIL ab_no_done got=%b exp=00", {term_valid, done}); end
  endtask

  task automatic test_async_reset();
    logic [23:0] bw;
    bw = '0; bw[0+:3] = 3'b001; bw[9+:3] = 3'b100; bw[18+:3] = 3'b011;
    BPR_W = bw; ETC_W = 4'd3; ETC_A = 4'd5; MDecomp = 1; in_valid = 1; term_ready = 1;
    step(); in_valid = 0;
    total++; if (term_valid !== 1'b1) begin bad++; $display("FAIL ar_running got=%b exp=1", term_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (allo !== 15'd0) begin bad++; $display("FAIL ar_outputs got=%h exp=0", allo); end
    #1 rst = 1'b0;
    step();
    test_weight();
  endtask

  initial begin
    test_reset();
    test_weight();
    test_awdecomp();
    test_zero_job();
    test_back_to_back();
    test_mismatch_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
